rx_frame_loader: RTL and testbench
==================================

# rx_frame_loader

Upstream loader for the matrix-vector processor array. It parses a byte stream from the UART receiver into framed commands. It stores the matrix size, the N×N matrix and the N-element vector in registers. It issues a one-cycle start pulse to the processor chain once all operands are loaded and the array is idle.

## Interface
Parameters:
- DATA_W, 8, element and byte width (DataIn_t)
- MAX_N, 8, maximum matrix dimension; MAX_N*MAX_N+1 ≤ 255

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- rx_data  in  DATA_W  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure
- busy_i  in  1  processor array running
- size_o  out  DATA_W  current N
- matrix_o  out  MAX_N*MAX_N*DATA_W  row-major flat, element k at bits [k*DATA_W +: DATA_W]
- vector_o  out  MAX_N*DATA_W  element i at [i*DATA_W +: DATA_W]
- ready_o  out  1  size, matrix and vector all valid
- start_o  out  1  one-cycle start pulse
- err_o  out  1  one-cycle error pulse
- err_code_o  out  3  last error cause, held until next error

## Operation
- Frame format: 0xFE, LEN, CMD, payload, [CHK], 0xEF. LEN = 1 + payload bytes.
- Commands and their fixed LEN:
  - 0x01 SIZE: payload N, LEN=2.
  - 0x02 MATRIX: N*N bytes, LEN=1+N*N.
  - 0x03 VECTOR: N bytes, LEN=1+N.
  - 0x04 START: LEN=1.
- FSM states: IDLE → LEN → CMD → PAYLOAD (skipped when LEN=1) → [CHK] → END → IDLE.
- State advances only on rx_valid.
- In IDLE, bytes other than 0xFE are dropped silently. Inside a frame 0xFE is ordinary data; there is no escaping.
- At CMD: an unknown CMD gives err_code 1 (CMD). A LEN not equal to the expected value for that CMD and the current N gives err_code 2 (LEN). MATRIX or VECTOR received while N=0 also gives code 2.
- SIZE payload 0 or greater than MAX_N gives err_code 3 (RANGE).
- Payload bytes are written directly into storage at index cnt. cnt runs 0..LEN-2 and resets at each frame start.
- END byte other than 0xEF gives err_code 4 (END).
- Commit at a good END:
  - SIZE: updates size_o, clears mat_loaded and vec_loaded.
  - MATRIX: sets mat_loaded.
  - VECTOR: sets vec_loaded.
  - START: if ready_o=1 and busy_i=0, pulses start_o. Otherwise error, code 5 (NOTREADY) or 6 (BUSY); BUSY takes priority.
- Any error:
  - err_o pulses and err_code_o updates.
  - The FSM returns to IDLE, discarding the rest of the frame.
  - An error in a MATRIX or VECTOR frame clears that loaded flag, because storage is partially overwritten.
  - A SIZE frame error leaves size_o unchanged.
- ready_o = (size_o≠0) & mat_loaded & vec_loaded.
- Storage outside N×N / N is not cleared and its content is don't-care.

## Timing
- Reset values: size_o=0, matrix_o=0, vector_o=0, ready_o=0, start_o=0, err_o=0, err_code_o=0, state IDLE, cnt=0.
- Reset mid-frame discards the frame and clears all stored operands.
- Stored elements, size_o and the loaded flags update on the clock edge after the accepting rx_valid.
- start_o and err_o go high exactly one cycle after the byte that causes them, for one cycle.
- Back-to-back rx_valid on every cycle is supported.
- busy_i is sampled in the same cycle the END byte is accepted.
- There is no timeout; a partial frame waits indefinitely.

## Configuration
- CHECKSUM_EN defined:
  - The CHK state is present.
  - The CHK byte is the XOR of LEN, CMD and all payload bytes.
  - A mismatch gives err_code 7 (CHK) and returns to IDLE.
  - Frames are one byte longer.
- CHECKSUM_EN undefined: no CHK state; the byte after the payload is the END byte.

## Structure
- Package ControlRx_in holds:
  - DataIn_t, Matriz_t, One_t.
  - Command constants: SOF=0xFE, EOF=0xEF, CMD_* values.
  - An err-code enum.
  - The FSM state enum.
- One sub-module, rx_operand_store: matrix/vector register file with write-enable, select and index inputs, and flat outputs.
- rx_frame_loader holds the FSM, counters, checks and flags.

## Test plan
- Size frame: FE 02 01 03 EF → size_o=3, ready_o=0, no err_o.
- Matrix frame after size 3: FE 0A 02 01..09 EF → matrix_o[0..8]=1..9. Then vector frame FE 04 03 0A 0B 0C EF → ready_o=1.
- Then FE 01 04 EF with busy_i=0 → start_o high for exactly one cycle, the cycle after EF.
- Same START frame with busy_i=1 → err_o pulse, err_code_o=6, no start_o.
- Bad end byte after size 3: FE 02 01 05 AA → err_code_o=4, size_o stays 3.
- Bad LEN: FE 03 01 04 00 EF → err_code_o=2 at the CMD byte. The trailing bytes are ignored until the next FE; a following valid frame is accepted.
- Reset asserted mid-matrix frame → all outputs return to 0. With CHECKSUM_EN defined, a wrong CHK → err_code_o=7.

Source files
------------

// File: rtl/rx_frame_loader_pkg.sv
// Shared types, framing constants and FSM/error encodings for the rx frame loader.
// Defining CHECKSUM_EN adds the checksum state to the FSM encoding.
package ControlRx_in;

    localparam int unsigned DataW = 8;
    localparam int unsigned MaxN  = 8;

    typedef logic [DataW-1:0]         DataIn_t;
    typedef DataIn_t [MaxN*MaxN-1:0]  Matriz_t;
    typedef logic                     One_t;

    localparam DataIn_t SOF        = 8'hFE;
    localparam DataIn_t EOF        = 8'hEF;
    localparam DataIn_t CMD_SIZE   = 8'h01;
    localparam DataIn_t CMD_MATRIX = 8'h02;
    localparam DataIn_t CMD_VECTOR = 8'h03;
    localparam DataIn_t CMD_START  = 8'h04;

    typedef enum logic [2:0] {
        ErrNone     = 3'd0,
        ErrCmd      = 3'd1,
        ErrLen      = 3'd2,
        ErrRange    = 3'd3,
        ErrEnd      = 3'd4,
        ErrNotReady = 3'd5,
        ErrBusy     = 3'd6,
        ErrChk      = 3'd7
    } err_code_e;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StCmd,
        StPayload,
        StEnd
`ifdef CHECKSUM_EN
        , StChk
`endif
    } state_e;

endpackage

// File: rtl/rx_operand_store.sv
// Matrix/vector operand register file; one element written per cycle at a flat index.
module rx_operand_store
    import ControlRx_in::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned MAX_N  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we_i,
    input  logic                          sel_mat_i,
    input  logic [DATA_W-1:0]             idx_i,
    input  logic [DATA_W-1:0]             wdata_i,
    output logic [MAX_N*MAX_N*DATA_W-1:0] matrix_o,
    output logic [MAX_N*DATA_W-1:0]       vector_o
);

    logic [MAX_N*MAX_N-1:0][DATA_W-1:0] mat_q;
    logic [MAX_N-1:0][DATA_W-1:0]       vec_q;

    // Index compare per entry keeps out-of-range indices harmless.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mat_q <= '0;
            vec_q <= '0;
        end else if (we_i) begin
            if (sel_mat_i) begin
                for (int k = 0; k < MAX_N * MAX_N; k++) begin
                    if (int'(idx_i) == k) mat_q[k] <= wdata_i;
                end
            end else begin
                for (int k = 0; k < MAX_N; k++) begin
                    if (int'(idx_i) == k) vec_q[k] <= wdata_i;
                end
            end
        end
    end

    assign matrix_o = mat_q;
    assign vector_o = vec_q;

endmodule

// File: rtl/rx_frame_loader.sv
// Parses framed UART commands into size/matrix/vector operands and issues the array start pulse.
// Optional CHECKSUM_EN adds an XOR checksum byte before the end byte.
module rx_frame_loader
    import ControlRx_in::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned MAX_N  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             rx_data,
    input  logic                          rx_valid,
    input  logic                          busy_i,
    output logic [DATA_W-1:0]             size_o,
    output logic [MAX_N*MAX_N*DATA_W-1:0] matrix_o,
    output logic [MAX_N*DATA_W-1:0]       vector_o,
    output logic                          ready_o,
    output logic                          start_o,
    output logic                          err_o,
    output logic [2:0]                    err_code_o
);

`ifdef CHECKSUM_EN
    localparam state_e StAfterPayload = StChk;
`else
    localparam state_e StAfterPayload = StEnd;
`endif

    state_e            state_q, state_d;
    logic [DATA_W-1:0] cnt_q, cnt_d, len_q, len_d, cmd_q, cmd_d, chk_q, chk_d;
    logic [DATA_W-1:0] size_q, size_d, size_pend_q, size_pend_d;
    One_t              mat_loaded_q, mat_loaded_d, vec_loaded_q, vec_loaded_d;
    logic              start_q, start_d, err_q, err_d;
    err_code_e         err_code_q, err_code_d, fail_code;
    logic              fail, store_we, ready;
    logic              cmd_known, needs_n, len_ok;
    logic [15:0]       n_ext, exp_len;

    assign ready = (size_q != '0) && mat_loaded_q && vec_loaded_q;

    // Expected LEN for the command byte currently on rx_data.
    always_comb begin
        n_ext     = 16'(size_q);
        cmd_known = 1'b1;
        if (rx_data == DATA_W'(CMD_SIZE))        exp_len = 16'd2;
        else if (rx_data == DATA_W'(CMD_MATRIX)) exp_len = 16'd1 + n_ext * n_ext;
        else if (rx_data == DATA_W'(CMD_VECTOR)) exp_len = 16'd1 + n_ext;
        else if (rx_data == DATA_W'(CMD_START))  exp_len = 16'd1;
        else begin
            exp_len   = '0;
            cmd_known = 1'b0;
        end
        needs_n = (rx_data == DATA_W'(CMD_MATRIX)) || (rx_data == DATA_W'(CMD_VECTOR));
        len_ok  = (16'(len_q) == exp_len) && !(needs_n && size_q == '0);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        cmd_d        = cmd_q;
        chk_d        = chk_q;
        size_d       = size_q;
        size_pend_d  = size_pend_q;
        mat_loaded_d = mat_loaded_q;
        vec_loaded_d = vec_loaded_q;
        start_d      = 1'b0;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        fail         = 1'b0;
        fail_code    = ErrNone;
        store_we     = 1'b0;
        if (rx_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_data == DATA_W'(SOF)) begin
                        state_d = StLen;
                        cnt_d   = '0;
                    end
                end
                StLen: begin
                    len_d   = rx_data;
                    chk_d   = rx_data;
                    state_d = StCmd;
                end
                StCmd: begin
                    cmd_d = rx_data;
                    chk_d = chk_q ^ rx_data;
                    if (!cmd_known) begin
                        fail      = 1'b1;
                        fail_code = ErrCmd;
                    end else if (!len_ok) begin
                        fail      = 1'b1;
                        fail_code = ErrLen;
                    end else if (len_q == DATA_W'(1)) begin
                        state_d = StAfterPayload;
                    end else begin
                        state_d = StPayload;
                    end
                end
                StPayload: begin
                    chk_d = chk_q ^ rx_data;
                    cnt_d = cnt_q + DATA_W'(1);
                    if (cmd_q == DATA_W'(CMD_SIZE)) begin
                        if (rx_data == '0 || rx_data > DATA_W'(MAX_N)) begin
                            fail      = 1'b1;
                            fail_code = ErrRange;
                        end else begin
                            size_pend_d = rx_data;
                        end
                    end else begin
                        store_we = 1'b1;
                    end
                    if (cnt_q == len_q - DATA_W'(2)) state_d = StAfterPayload;
                end
`ifdef CHECKSUM_EN
                StChk: begin
                    if (rx_data != chk_q) begin
                        fail      = 1'b1;
                        fail_code = ErrChk;
                    end else begin
                        state_d = StEnd;
                    end
                end
`endif
                StEnd: begin
                    state_d = StIdle;
                    if (rx_data != DATA_W'(EOF)) begin
                        fail      = 1'b1;
                        fail_code = ErrEnd;
                    end else if (cmd_q == DATA_W'(CMD_SIZE)) begin
                        size_d       = size_pend_q;
                        mat_loaded_d = 1'b0;
                        vec_loaded_d = 1'b0;
                    end else if (cmd_q == DATA_W'(CMD_MATRIX)) begin
                        mat_loaded_d = 1'b1;
                    end else if (cmd_q == DATA_W'(CMD_VECTOR)) begin
                        vec_loaded_d = 1'b1;
                    end else if (busy_i) begin
                        fail      = 1'b1;
                        fail_code = ErrBusy;
                    end else if (!ready) begin
                        fail      = 1'b1;
                        fail_code = ErrNotReady;
                    end else begin
                        start_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (fail) begin
                err_d      = 1'b1;
                err_code_d = fail_code;
                state_d    = StIdle;
                // Past CMD the payload may already have overwritten part of the operand.
                if (state_q != StCmd) begin
                    if (cmd_q == DATA_W'(CMD_MATRIX)) mat_loaded_d = 1'b0;
                    if (cmd_q == DATA_W'(CMD_VECTOR)) vec_loaded_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            len_q        <= '0;
            cmd_q        <= '0;
            chk_q        <= '0;
            size_q       <= '0;
            size_pend_q  <= '0;
            mat_loaded_q <= 1'b0;
            vec_loaded_q <= 1'b0;
            start_q      <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ErrNone;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            cmd_q        <= cmd_d;
            chk_q        <= chk_d;
            size_q       <= size_d;
            size_pend_q  <= size_pend_d;
            mat_loaded_q <= mat_loaded_d;
            vec_loaded_q <= vec_loaded_d;
            start_q      <= start_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    rx_operand_store #(
        .DATA_W (DATA_W),
        .MAX_N  (MAX_N)
    ) u_store (
        .clk       (clk),
        .reset     (reset),
        .we_i      (store_we),
        .sel_mat_i (cmd_q == DATA_W'(CMD_MATRIX)),
        .idx_i     (cnt_q),
        .wdata_i   (rx_data),
        .matrix_o  (matrix_o),
        .vector_o  (vector_o)
    );

    assign size_o     = size_q;
    assign ready_o    = ready;
    assign start_o    = start_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;

endmodule

// File: tb/tb_rx_frame_loader.sv
// Bench for rx_frame_loader: directed frames plus randomized frames checked against a
// frame-level reference model. Honours CHECKSUM_EN like the design.
module tb_rx_frame_loader;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned MAX_N  = 8;

    typedef logic [7:0] byte_q_t[$];

    logic                          clk = 1'b0;
    logic                          reset;
    logic [DATA_W-1:0]             rx_data;
    logic                          rx_valid;
    logic                          busy_i;
    logic [DATA_W-1:0]             size_o;
    logic [MAX_N*MAX_N*DATA_W-1:0] matrix_o;
    logic [MAX_N*DATA_W-1:0]       vector_o;
    logic                          ready_o, start_o, err_o;
    logic [2:0]                    err_code_o;

    always #5 clk = ~clk;

    rx_frame_loader #(
        .DATA_W (DATA_W),
        .MAX_N  (MAX_N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .busy_i     (busy_i),
        .size_o     (size_o),
        .matrix_o   (matrix_o),
        .vector_o   (vector_o),
        .ready_o    (ready_o),
        .start_o    (start_o),
        .err_o      (err_o),
        .err_code_o (err_code_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: operands as plain arrays, flags as bits.
    int m_size;
    int m_mat[MAX_N*MAX_N];
    int m_vec[MAX_N];
    bit m_mat_ok, m_vec_ok;
    int m_err_code;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_size = 0;
        foreach (m_mat[k]) m_mat[k] = 0;
        foreach (m_vec[k]) m_vec[k] = 0;
        m_mat_ok   = 0;
        m_vec_ok   = 0;
        m_err_code = 0;
    endtask

    function automatic byte_q_t seq_pay(input int first, input int count);
        byte_q_t q;
        for (int i = 0; i < count; i++) q.push_back(8'(first + i));
        return q;
    endfunction

    function automatic byte_q_t mk_frame(input int len, input int cmd, input byte_q_t pay,
                                         input int endb, input bit bad_chk);
        byte_q_t f;
        logic [7:0] c;
        f.push_back(8'hFE);
        f.push_back(8'(len));
        f.push_back(8'(cmd));
        c = 8'(len) ^ 8'(cmd);
        foreach (pay[i]) begin
            f.push_back(pay[i]);
            c = c ^ pay[i];
        end
`ifdef CHECKSUM_EN
        f.push_back(bad_chk ? ~c : c);
`else
        if (bad_chk) c = ~c;
`endif
        f.push_back(8'(endb));
        return f;
    endfunction

    // Applies one frame to the reference state; reports error code, the index of the
    // deciding byte and whether a start pulse is due.
    task automatic model_frame(input byte_q_t fr, input bit busy,
                               output int err, output int pos, output bit start);
        int len, cmd, n, exp_len, p, chk, b;
        err = 0; pos = -1; start = 0;
        len = int'(fr[1]);
        cmd = int'(fr[2]);
        n   = m_size;
        case (cmd)
            1:       exp_len = 2;
            2:       exp_len = 1 + n * n;
            3:       exp_len = 1 + n;
            4:       exp_len = 1;
            default: exp_len = -1;
        endcase
        if (exp_len < 0) begin
            err = 1; pos = 2;
        end else if (len != exp_len || ((cmd == 2 || cmd == 3) && n == 0)) begin
            err = 2; pos = 2;
        end else begin
            chk = len ^ cmd;
            p = 3;
            for (int i = 0; i < len - 1 && err == 0; i++) begin
                b = int'(fr[p]);
                chk = chk ^ b;
                if (cmd == 1 && (b == 0 || b > int'(MAX_N))) begin
                    err = 3; pos = p;
                end else if (cmd == 2) m_mat[i] = b;
                else if (cmd == 3) m_vec[i] = b;
                p++;
            end
`ifdef CHECKSUM_EN
            if (err == 0) begin
                if (int'(fr[p]) != chk) begin
                    err = 7; pos = p;
                end
                p++;
            end
`endif
            if (err == 0) begin
                pos = p;
                if (fr[p] != 8'hEF) err = 4;
                else if (cmd == 1) begin
                    m_size = int'(fr[3]); m_mat_ok = 0; m_vec_ok = 0;
                end else if (cmd == 2) m_mat_ok = 1;
                else if (cmd == 3) m_vec_ok = 1;
                else if (busy) err = 6;
                else if (!(m_size != 0 && m_mat_ok && m_vec_ok)) err = 5;
                else start = 1;
            end
            if (err >= 3 && cmd == 2) m_mat_ok = 0;
            if (err >= 3 && cmd == 3) m_vec_ok = 0;
        end
        if (err != 0) m_err_code = err;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_size"}, int'(size_o), m_size);
        check_eq({tag, "_ready"}, int'(ready_o), int'(m_size != 0 && m_mat_ok && m_vec_ok));
        check_eq({tag, "_err_code"}, int'(err_code_o), m_err_code);
        for (int k = 0; k < m_size * m_size; k++)
            check_eq({tag, "_mat_elem"}, int'(matrix_o[k*8 +: 8]), m_mat[k]);
        for (int k = 0; k < m_size; k++)
            check_eq({tag, "_vec_elem"}, int'(vector_o[k*8 +: 8]), m_vec[k]);
    endtask

    task automatic run_frame(input string tag, input byte_q_t fr, input bit busy, input bit gaps);
        int err, pos;
        bit st;
        busy_i = busy;
        model_frame(fr, busy, err, pos, st);
        // Bytes after an error are scanned in idle; keep them free of stray frame starts.
        for (int i = pos + 1; i < fr.size(); i++) if (fr[i] == 8'hFE) fr[i] = 8'h00;
        for (int i = 0; i < fr.size(); i++) begin
            if (gaps && $urandom_range(3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            @(negedge clk);
            rx_data  = fr[i];
            rx_valid = 1'b1;
            @(posedge clk);
            #1;
            rx_valid = 1'b0;
            check_eq({tag, "_err_pulse"}, int'(err_o), int'(err != 0 && i == pos));
            check_eq({tag, "_start_pulse"}, int'(start_o), int'(st && i == pos));
        end
        @(posedge clk);
        #1;
        check_eq({tag, "_err_width"}, int'(err_o), 0);
        check_eq({tag, "_start_width"}, int'(start_o), 0);
        check_state(tag);
    endtask

    initial begin
        byte_q_t pay;
        int sel, cmd, len, n, endb;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        busy_i   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_matrix_zero", int'(matrix_o != '0), 0);
        check_eq("rst_vector_zero", int'(vector_o != '0), 0);
        check_eq("rst_start", int'(start_o), 0);
        check_eq("rst_err", int'(err_o), 0);
        check_state("rst");
        reset = 1'b1;

        run_frame("size3", mk_frame(2, 1, seq_pay(3, 1), 8'hEF, 0), 0, 0);
        run_frame("matrix", mk_frame(10, 2, seq_pay(1, 9), 8'hEF, 0), 0, 0);
        run_frame("vector", mk_frame(4, 3, seq_pay(10, 3), 8'hEF, 0), 0, 0);
        run_frame("start_ok", mk_frame(1, 4, seq_pay(0, 0), 8'hEF, 0), 0, 0);
        run_frame("start_busy", mk_frame(1, 4, seq_pay(0, 0), 8'hEF, 0), 1, 0);
        run_frame("bad_end", mk_frame(2, 1, seq_pay(5, 1), 8'hAA, 0), 0, 0);
        pay = {8'h04, 8'h00};
        run_frame("bad_len", mk_frame(3, 1, pay, 8'hEF, 0), 0, 0);
        run_frame("size2", mk_frame(2, 1, seq_pay(2, 1), 8'hEF, 0), 0, 0);
        run_frame("not_ready", mk_frame(1, 4, seq_pay(0, 0), 8'hEF, 0), 0, 0);
        run_frame("bad_cmd", mk_frame(1, 9, seq_pay(0, 0), 8'hEF, 0), 0, 0);
        run_frame("size_zero", mk_frame(2, 1, seq_pay(0, 1), 8'hEF, 0), 0, 0);
        run_frame("size_big", mk_frame(2, 1, seq_pay(MAX_N + 1, 1), 8'hEF, 0), 0, 0);
        run_frame("size_max", mk_frame(2, 1, seq_pay(MAX_N, 1), 8'hEF, 0), 0, 0);
        run_frame("mat_fe", mk_frame(65, 2, seq_pay(200, 64), 8'hEF, 0), 0, 0);
`ifdef CHECKSUM_EN
        run_frame("bad_chk", mk_frame(2, 1, seq_pay(4, 1), 8'hEF, 1), 0, 0);
`endif

        // Reset in the middle of a matrix frame.
        pay = {8'hFE, 8'h41, 8'h02, 8'h11, 8'h22, 8'h33};
        foreach (pay[i]) begin
            @(negedge clk);
            rx_data  = pay[i];
            rx_valid = 1'b1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b0;
        model_reset();
        #1;
        check_eq("midrst_matrix_zero", int'(matrix_o != '0), 0);
        check_eq("midrst_vector_zero", int'(vector_o != '0), 0);
        check_state("midrst");
        @(negedge clk);
        reset = 1'b1;
        run_frame("after_rst", mk_frame(2, 1, seq_pay(1, 1), 8'hEF, 0), 0, 0);

        repeat (200) begin
            pay.delete();
            sel = int'($urandom_range(9));
            n   = 0;
            if (sel <= 2) begin
                cmd = 1; len = 2;
                n = ($urandom_range(5) == 0) ? int'($urandom_range(0, MAX_N + 1))
                                             : int'($urandom_range(1, 3));
            end else if (sel <= 4) begin
                cmd = 2; len = 1 + m_size * m_size;
            end else if (sel <= 6) begin
                cmd = 3; len = 1 + m_size;
            end else if (sel <= 8) begin
                cmd = 4; len = 1;
            end else begin
                cmd = int'($urandom_range(5, 255)); len = int'($urandom_range(1, 4));
            end
            if ($urandom_range(9) == 0) len = int'($urandom_range(1, 12));
            for (int i = 0; i < len - 1; i++)
                pay.push_back((cmd == 1 && i == 0) ? 8'(n) : 8'($urandom_range(255)));
            endb = ($urandom_range(11) == 0) ? int'($urandom_range(255)) : 8'hEF;
            run_frame("rand", mk_frame(len, cmd, pay, endb, $urandom_range(11) == 0),
                      $urandom_range(3) == 0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
